// File: rtl/attn_pkg.sv
// Shared sizing, FSM states, operand-source and error codes for the attention job scheduler.
package attn_pkg;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int NUM_JOBS = 5;

    typedef enum logic [2:0] {
        IDLE, HDR_READ, HDR_CAPTURE, CHECK, ISSUE, WAIT_DONE, DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_INPUT  = 2'd0,
        SRC_WEIGHT = 2'd1,
        SRC_RESULT = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DIM  = 2'd1,
        ERR_ZERO = 2'd2,
        ERR_ADDR = 2'd3
    } err_t;
endpackage

// File: rtl/attn_job_table.sv
// Combinational descriptor lookup: maps a job index and the (N, D) shape to the
// operand sources, base addresses and matmul dimensions of that attention step.
module attn_job_table #(
    parameter int ADDR_W = 16
) (
    input  logic [2:0]        job_id,
    input  logic [15:0]       n,
    input  logic [15:0]       d,
    output logic [1:0]        a_src,
    output logic [1:0]        b_src,
    output logic [ADDR_W-1:0] a_base,
    output logic [ADDR_W-1:0] b_base,
    output logic [ADDR_W-1:0] out_base,
    output logic              b_transpose,
    output logic [15:0]       rows,
    output logic [15:0]       inner,
    output logic [15:0]       cols
);
    import attn_pkg::*;

    // P = one D x D weight block, Q = one N x D activation block
    logic [31:0] p, q, nn;
    assign p  = {16'd0, d} * {16'd0, d};
    assign q  = {16'd0, n} * {16'd0, d};
    assign nn = {16'd0, n} * {16'd0, n};

    always_comb begin
        a_src       = SRC_INPUT;
        b_src       = SRC_WEIGHT;
        a_base      = ADDR_W'(1);
        b_base      = ADDR_W'(1);
        out_base    = '0;
        b_transpose = 1'b0;
        rows        = n;
        inner       = d;
        cols        = d;
        case (job_id)
            3'd1: begin
                b_base   = ADDR_W'(32'd1 + p);
                out_base = ADDR_W'(q);
            end
            3'd2: begin
                b_base   = ADDR_W'(32'd1 + 32'd2 * p);
                out_base = ADDR_W'(32'd2 * q);
            end
            3'd3: begin
                a_src       = SRC_RESULT;
                b_src       = SRC_RESULT;
                a_base      = '0;
                b_base      = ADDR_W'(q);
                out_base    = ADDR_W'(32'd3 * q);
                b_transpose = 1'b1;
                cols        = n;
            end
            3'd4: begin
                a_src    = SRC_RESULT;
                b_src    = SRC_RESULT;
                a_base   = ADDR_W'(32'd3 * q);
                b_base   = ADDR_W'(32'd2 * q);
                out_base = ADDR_W'(32'd3 * q + nn);
                inner    = n;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/attn_job_scheduler.sv
// Reads the input/weight headers, validates the shapes, then sequences the five
// attention matmul jobs through the engine one at a time.
module attn_job_scheduler #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic              hdr_rd_sel,
    input  logic [DATA_W-1:0] input_hdr_data,
    input  logic [DATA_W-1:0] weight_hdr_data,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [2:0]        job_id,
    output logic [1:0]        job_a_src,
    output logic [1:0]        job_b_src,
    output logic [ADDR_W-1:0] job_a_base,
    output logic [ADDR_W-1:0] job_b_base,
    output logic [ADDR_W-1:0] job_out_base,
    output logic              job_b_transpose,
    output logic [15:0]       job_rows,
    output logic [15:0]       job_inner,
    output logic [15:0]       job_cols,
    input  logic              job_done,
    output logic [1:0]        sched_err
);
    import attn_pkg::*;

    localparam logic [32:0] ADDR_SPACE = 33'(1) << ADDR_W;

    state_t      state_q, state_d;
    logic [2:0]  job_id_q, job_id_d;
    logic        load_job;
    logic [15:0] n_q, d_q, wr_q, wc_q;
    err_t        err_q, chk_err;
    logic [31:0] dd, nd, nn;

    logic [1:0]        t_a_src, t_b_src;
    logic [ADDR_W-1:0] t_a_base, t_b_base, t_out_base;
    logic              t_b_transpose;
    logic [15:0]       t_rows, t_inner, t_cols;

    // Looked up with the next job index so the descriptor is registered on ISSUE entry
    attn_job_table #(.ADDR_W(ADDR_W)) u_job_table (
        .job_id      (job_id_d),
        .n           (n_q),
        .d           (d_q),
        .a_src       (t_a_src),
        .b_src       (t_b_src),
        .a_base      (t_a_base),
        .b_base      (t_b_base),
        .out_base    (t_out_base),
        .b_transpose (t_b_transpose),
        .rows        (t_rows),
        .inner       (t_inner),
        .cols        (t_cols)
    );

    assign dd = {16'd0, d_q} * {16'd0, d_q};
    assign nd = {16'd0, n_q} * {16'd0, d_q};
    assign nn = {16'd0, n_q} * {16'd0, n_q};

    // Footprints: header word + three D x D weight blocks; four N x D blocks + N x N scores
    always_comb begin
        chk_err = ERR_NONE;
        if (n_q == '0 || d_q == '0)
            chk_err = ERR_ZERO;
        else if (wr_q != d_q || wc_q != d_q)
            chk_err = ERR_DIM;
        else if ({1'b0, 32'd1 + 32'd3 * dd} > ADDR_SPACE ||
                 {1'b0, 32'd4 * nd + nn} > ADDR_SPACE)
            chk_err = ERR_ADDR;
    end

    always_comb begin
        state_d  = state_q;
        job_id_d = job_id_q;
        load_job = 1'b0;
        case (state_q)
            IDLE:        if (dut_valid) state_d = HDR_READ;
            HDR_READ:    state_d = HDR_CAPTURE;
            HDR_CAPTURE: state_d = CHECK;
            CHECK: begin
                if (chk_err != ERR_NONE) begin
                    state_d = DONE;
                end else begin
                    state_d  = ISSUE;
                    job_id_d = '0;
                    load_job = 1'b1;
                end
            end
            ISSUE:       if (job_ready) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (job_done) begin
                    if (job_id_q == 3'(NUM_JOBS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ISSUE;
                        job_id_d = job_id_q + 3'd1;
                        load_job = 1'b1;
                    end
                end
            end
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            job_id_q <= '0;
        end else begin
            state_q  <= state_d;
            job_id_q <= job_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dut_ready       <= 1'b0;
            err_q           <= ERR_NONE;
            n_q             <= '0;
            d_q             <= '0;
            wr_q            <= '0;
            wc_q            <= '0;
            job_a_src       <= '0;
            job_b_src       <= '0;
            job_a_base      <= '0;
            job_b_base      <= '0;
            job_out_base    <= '0;
            job_b_transpose <= 1'b0;
            job_rows        <= '0;
            job_inner       <= '0;
            job_cols        <= '0;
        end else begin
            dut_ready <= (state_q == IDLE) && !dut_valid;
            if (state_q == IDLE && dut_valid)
                err_q <= ERR_NONE;
            else if (state_q == CHECK)
                err_q <= chk_err;
            if (state_q == HDR_CAPTURE) begin
                n_q  <= input_hdr_data[31:16];
                d_q  <= input_hdr_data[15:0];
                wr_q <= weight_hdr_data[31:16];
                wc_q <= weight_hdr_data[15:0];
            end
            if (load_job) begin
                job_a_src       <= t_a_src;
                job_b_src       <= t_b_src;
                job_a_base      <= t_a_base;
                job_b_base      <= t_b_base;
                job_out_base    <= t_out_base;
                job_b_transpose <= t_b_transpose;
                job_rows        <= t_rows;
                job_inner       <= t_inner;
                job_cols        <= t_cols;
            end
        end
    end

    assign job_valid  = (state_q == ISSUE);
    assign hdr_rd_sel = (state_q == HDR_READ) || (state_q == HDR_CAPTURE);
    assign job_id     = job_id_q;
    assign sched_err  = err_q;
endmodule

// File: doc/attn_job_scheduler.md
ATTN_JOB_SCHEDULER -- requirements
Module: attn_job_scheduler

Interface
REQ-001 Parameter ADDR_W, 16, SRAM address width.
REQ-002 Parameter DATA_W, 32, SRAM data width.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 dut_valid  in  1  start request from the testbench.
REQ-006 dut_ready  out  1  registered; high means idle and accepting.
REQ-007 hdr_rd_sel  out  1  high means the scheduler owns the input/weight SRAM read ports; top drives both read addresses to 0.
REQ-008 input_hdr_data, weight_hdr_data  in  DATA_W  SRAM read data (one-cycle read latency); [31:16]=rows, [15:0]=cols.
REQ-009 job_valid / job_ready  out / in  1  matmul-engine job handshake.
REQ-010 job_id  out  3  job index 0..4.
REQ-011 job_a_src, job_b_src  out  2  operand SRAM select: 0=input, 1=weight, 2=result.
REQ-012 job_a_base, job_b_base, job_out_base  out  ADDR_W  operand and result base addresses.
REQ-013 job_b_transpose  out  1  engine reads B column-major.
REQ-014 job_rows, job_inner, job_cols  out  16  M, K and N of the job.
REQ-015 job_done  in  1  single-cycle completion pulse from the engine.
REQ-016 sched_err  out  2  0=none, 1=dimension mismatch, 2=zero dimension, 3=address overflow.

Function
REQ-017 States SHALL be IDLE, HDR_READ, HDR_CAPTURE, CHECK, ISSUE, WAIT_DONE, DONE.
REQ-018 IDLE->HDR_READ when dut_valid is sampled high; dut_valid in any other state SHALL be ignored.
REQ-019 hdr_rd_sel SHALL be high in HDR_READ and HDR_CAPTURE only.
REQ-020 HDR_CAPTURE SHALL register N=input[31:16], D=input[15:0], WR=weight[31:16], WC=weight[15:0].
REQ-021 CHECK SHALL compute all products in 32 bits and set sched_err by priority: N or D zero ->2; WR!=D or WC!=D ->1; 1+3*D*D>2^ADDR_W or 4*N*D+N*N>2^ADDR_W ->3.
REQ-022 CHECK->DONE when there is an error, else ->ISSUE with job_id=0.
REQ-023 Job table (P=D*D, Q=N*D):
  J0: A input@1, B weight@1, out 0, N x D x D.
  J1: A input@1, B weight@1+P, out Q, N x D x D.
  J2: A input@1, B weight@1+2P, out 2Q, N x D x D.
  J3: A result@0, B result@Q transposed, out 3Q, N x D x N.
  J4: A result@3Q, B result@2Q, out 3Q+N*N, N x N x D.
REQ-024 job_valid SHALL be high exactly in ISSUE.
REQ-025 All job_* outputs SHALL hold stable from ISSUE entry until the job_ready handshake.
REQ-026 ISSUE->WAIT_DONE on job_valid&&job_ready.
REQ-027 In WAIT_DONE, job_done SHALL take job_id<4 to ISSUE with job_id+1, and job_id==4 to DONE.
REQ-028 job_done outside WAIT_DONE SHALL be ignored.
REQ-029 DONE SHALL last one cycle, then IDLE.
REQ-030 dut_ready SHALL be registered as (state==IDLE && !dut_valid): low the cycle after acceptance, high the cycle after the first idle cycle without dut_valid.
REQ-031 sched_err SHALL hold until the next accepted dut_valid, which clears it.
REQ-032 Latency: with dut_valid sampled at edge E0, job_valid SHALL first rise in the cycle following edge E0+3.

Reset
REQ-033 While reset_n is sampled low: state=IDLE; all outputs 0; job fields, dims and sched_err 0.
REQ-034 Reset mid-job SHALL abort with no further job_valid; dut_ready SHALL reassert per REQ-030.

Structure
REQ-035 Package attn_pkg SHALL hold the state enum, the source-select enum (SRC_INPUT/SRC_WEIGHT/SRC_RESULT), the error enum, ADDR_W, DATA_W and NUM_JOBS=5.
REQ-036 Sub-module attn_job_table (combinational; job_id, N, D -> descriptor) SHALL be instantiated once.

Verification
REQ-037 N=4, D=8, weight header 8x8, engine job_ready=1 with done 3 cycles later -> bases: B 1/65/129; out 0/32/64/96/112; J3 transpose=1 and dims 4x8x4; J4 dims 4x4x8; sched_err=0; dut_ready returns high.
REQ-038 Weight header 8x4 with D=8 -> sched_err=1, job_valid never high, DONE then IDLE.
REQ-039 N=0, D=8 -> sched_err=2; then a valid N=2, D=2 run -> sched_err cleared, 5 jobs issued.
REQ-040 N=200, D=200 -> sched_err=3, no jobs issued.
REQ-041 job_ready held low for 5 cycles on J1 -> job_valid and all job fields stable for those cycles, J1 accepted on cycle 6.
REQ-042 reset_n low for one cycle during J2 WAIT_DONE -> next cycle job_valid=0, state IDLE, a subsequent job_done is ignored, dut_ready=1 two cycles later.
